// File: rtl/mem_stage_if.sv
// Pipeline handshake and data-SRAM response signals between the pipeline and the MEM stage.
// The slave modport is the MEM stage's own view.
interface mem_stage_if;
    logic        mem_valid_i;
    logic        mem_allowin_o;
    logic        mem_to_wb_valid_o;
    logic        wb_allowin_i;
    logic        excep_flush_i;
    logic        data_ok_i;
    logic [31:0] rdata_i;

    modport master (
        output mem_valid_i,
        input  mem_allowin_o,
        input  mem_to_wb_valid_o,
        output wb_allowin_i,
        output excep_flush_i,
        output data_ok_i,
        output rdata_i
    );

    modport slave (
        input  mem_valid_i,
        output mem_allowin_o,
        output mem_to_wb_valid_o,
        input  wb_allowin_i,
        input  excep_flush_i,
        input  data_ok_i,
        input  rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// LoongArch MEM stage: waits for and buffers the data-SRAM response, aligns load data,
// builds the MEM->WB bus and ID forwarding info, and drops responses of flushed loads.
module mem_stage #(
    parameter int unsigned CANCEL_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        mem_req_i,
    input  logic [2:0]  load_type_i,
    input  logic [1:0]  addr_low_i,
    input  logic [31:0] alu_result_i,
    input  logic        rf_we_i,
    input  logic [4:0]  rf_waddr_i,
    input  logic        excep_i,
    output logic [63:0] pc_inst_obus,
    output logic [38:0] mem_to_wb_obus,
    output logic        fwd_we_o,
    output logic [4:0]  fwd_waddr_o,
    output logic [31:0] fwd_wdata_o,
    output logic        fwd_load_pending_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_buf_valid;
    logic [31:0]         r_buf_data;
    logic [CANCEL_W-1:0] r_cancel_cnt;

    logic        w_valid;
    logic        w_resp_hit;
    logic        w_drop;
    logic        w_got;
    logic        w_ready_go;
    logic        w_leave;
    logic        w_capture;
    logic        w_rf_we;
    logic [31:0] w_raw;
    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;
    logic [31:0] w_aligned;
    logic [31:0] w_rf_wdata;

    // Reset masks the incoming valid so every output is quiet while rst_n is low.
    assign w_valid    = bus.mem_valid_i & rst_n;
    assign w_drop     = bus.data_ok_i & (|r_cancel_cnt);
    assign w_resp_hit = bus.data_ok_i & ~(|r_cancel_cnt);
    assign w_got      = r_buf_valid | w_resp_hit;
    assign w_ready_go = ~mem_req_i | excep_i | w_got;
    assign w_leave    = bus.mem_to_wb_valid_o & bus.wb_allowin_i;
    assign w_capture  = w_valid & mem_req_i & ~r_buf_valid & w_resp_hit
                      & ~bus.wb_allowin_i & ~bus.excep_flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_buf_valid  <= 1'b0;
            r_buf_data   <= '0;
            r_cancel_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (bus.excep_flush_i || w_leave) begin
                r_buf_valid <= 1'b0;
            end else if (w_capture) begin
                r_buf_valid <= 1'b1;
            end
            if (w_capture) begin
                r_buf_data <= bus.rdata_i;
            end
            // Responses return in order, so a stale one is always the next to arrive.
            if (w_drop) begin
                r_cancel_cnt <= r_cancel_cnt - 1'b1;
            end else if (bus.excep_flush_i && r_state == WAIT && !bus.data_ok_i
                         && r_cancel_cnt != '1) begin
                r_cancel_cnt <= r_cancel_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.excep_flush_i || w_leave) begin
            w_next = IDLE;
        end else if (w_capture) begin
            w_next = HOLD;
        end else if (r_state == IDLE && w_valid && mem_req_i && !w_resp_hit) begin
            w_next = WAIT;
        end
    end

    assign w_raw     = r_buf_valid ? r_buf_data : bus.rdata_i;
    assign w_byte_sh = w_raw >> {addr_low_i, 3'b000};
    assign w_half_sh = w_raw >> {addr_low_i[1], 4'b0000};

    always_comb begin
        w_aligned = '0;
        case (load_type_i)
            3'd1:    w_aligned = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            3'd2:    w_aligned = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
            3'd3:    w_aligned = w_raw;
            3'd4:    w_aligned = {24'd0, w_byte_sh[7:0]};
            3'd5:    w_aligned = {16'd0, w_half_sh[15:0]};
            default: w_aligned = '0;
        endcase
    end

    assign w_rf_wdata = (load_type_i != 3'd0) ? w_aligned : alu_result_i;
    assign w_rf_we    = rf_we_i & w_valid & ~excep_i;

    always_comb begin
        bus.mem_to_wb_valid_o = w_valid & w_ready_go & ~bus.excep_flush_i;
        bus.mem_allowin_o     = rst_n & (~w_valid | (w_ready_go & bus.wb_allowin_i));
        mem_to_wb_obus        = '0;
        fwd_waddr_o           = '0;
        fwd_wdata_o           = '0;
        if (w_valid) begin
            mem_to_wb_obus = {excep_i, w_rf_we, rf_waddr_i, w_rf_wdata};
            fwd_waddr_o    = rf_waddr_i;
            fwd_wdata_o    = w_rf_wdata;
        end
        fwd_we_o           = w_rf_we;
        fwd_load_pending_o = w_valid & (load_type_i != 3'd0) & ~w_got;
        pc_inst_obus       = rst_n ? {pc_i, inst_i} : '0;
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load alignment, stall, hold buffer,
// flush-cancelled responses and reset while a request is outstanding.
module tb_mem_stage;
    logic        clk;
    logic        rst_n;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        mem_req_i;
    logic [2:0]  load_type_i;
    logic [1:0]  addr_low_i;
    logic [31:0] alu_result_i;
    logic        rf_we_i;
    logic [4:0]  rf_waddr_i;
    logic        excep_i;
    logic [63:0] pc_inst_obus;
    logic [38:0] mem_to_wb_obus;
    logic        fwd_we_o;
    logic [4:0]  fwd_waddr_o;
    logic [31:0] fwd_wdata_o;
    logic        fwd_load_pending_o;

    int vectors;
    int miscompares;

    mem_stage_if bus ();

    mem_stage #(.CANCEL_W(2)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus                (bus),
        .pc_i               (pc_i),
        .inst_i             (inst_i),
        .mem_req_i          (mem_req_i),
        .load_type_i        (load_type_i),
        .addr_low_i         (addr_low_i),
        .alu_result_i       (alu_result_i),
        .rf_we_i            (rf_we_i),
        .rf_waddr_i         (rf_waddr_i),
        .excep_i            (excep_i),
        .pc_inst_obus       (pc_inst_obus),
        .mem_to_wb_obus     (mem_to_wb_obus),
        .fwd_we_o           (fwd_we_o),
        .fwd_waddr_o        (fwd_waddr_o),
        .fwd_wdata_o        (fwd_wdata_o),
        .fwd_load_pending_o (fwd_load_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] st();
        return {62'd0, dut.r_state};
    endfunction

    function automatic logic [63:0] cnt();
        return {62'd0, dut.r_cancel_cnt};
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        pc_i = 32'h1c00_0100; inst_i = 32'h0280_0000;
        mem_req_i = 1'b0; load_type_i = 3'd0; addr_low_i = 2'd0;
        alu_result_i = 32'h0; rf_we_i = 1'b1; rf_waddr_i = 5'd5; excep_i = 1'b0;
        bus.mem_valid_i = 1'b1; bus.wb_allowin_i = 1'b1; bus.excep_flush_i = 1'b0;
        bus.data_ok_i = 1'b0; bus.rdata_i = 32'h0;
        tick();
        tick();

        // Reset: outputs quiet even though mem_valid_i is high
        check("rst_to_wb_valid", {63'd0, bus.mem_to_wb_valid_o}, 64'd0);
        check("rst_allowin", {63'd0, bus.mem_allowin_o}, 64'd0);
        check("rst_obus", {25'd0, mem_to_wb_obus}, 64'd0);
        check("rst_fwd_we", {63'd0, fwd_we_o}, 64'd0);
        check("rst_pc_inst", pc_inst_obus, 64'd0);
        check("rst_state", st(), 64'd0);
        rst_n = 1'b1;

        // ADD: no memory request, passes straight through
        alu_result_i = 32'h0000_1234;
        #1;
        check("add_to_wb_valid", {63'd0, bus.mem_to_wb_valid_o}, 64'd1);
        check("add_allowin", {63'd0, bus.mem_allowin_o}, 64'd1);
        check("add_obus", {25'd0, mem_to_wb_obus}, {25'd0, 1'b0, 1'b1, 5'd5, 32'h0000_1234});
        check("add_fwd_wdata", {32'd0, fwd_wdata_o}, 64'h0000_1234);
        check("add_pc_inst", pc_inst_obus, 64'h1c00_0100_0280_0000);
        tick();

        // LD.B / LD.BU, byte 2, response in the same cycle
        mem_req_i = 1'b1; load_type_i = 3'd1; addr_low_i = 2'd2; rf_waddr_i = 5'd7;
        bus.data_ok_i = 1'b1; bus.rdata_i = 32'h12F4_5678;
        #1;
        check("ldb_to_wb_valid", {63'd0, bus.mem_to_wb_valid_o}, 64'd1);
        check("ldb_wdata", {32'd0, fwd_wdata_o}, 64'hFFFF_FFF4);
        check("ldb_pending", {63'd0, fwd_load_pending_o}, 64'd0);
        load_type_i = 3'd4;
        #1;
        check("ldbu_wdata", {32'd0, mem_to_wb_obus[31:0]}, 64'h0000_00F4);
        tick();
        check("ldb_state", st(), 64'd0);

        // LD.H / LD.HU, response three cycles late
        load_type_i = 3'd2; bus.data_ok_i = 1'b0; bus.rdata_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ldh_wait_valid", {63'd0, bus.mem_to_wb_valid_o}, 64'd0);
            check("ldh_wait_pending", {63'd0, fwd_load_pending_o}, 64'd1);
            check("ldh_wait_allowin", {63'd0, bus.mem_allowin_o}, 64'd0);
            tick();
            check("ldh_wait_state", st(), 64'd1);
        end
        bus.data_ok_i = 1'b1; bus.rdata_i = 32'h8001_ABCD;
        #1;
        check("ldh_valid", {63'd0, bus.mem_to_wb_valid_o}, 64'd1);
        check("ldh_wdata", {32'd0, fwd_wdata_o}, 64'hFFFF_8001);
        check("ldh_pending", {63'd0, fwd_load_pending_o}, 64'd0);
        load_type_i = 3'd5;
        #1;
        check("ldhu_wdata", {32'd0, fwd_wdata_o}, 64'h0000_8001);
        tick();
        check("ldh_state_idle", st(), 64'd0);

        // LD.W response buffered while WB stalls for two cycles
        load_type_i = 3'd3; addr_low_i = 2'd0; bus.wb_allowin_i = 1'b0;
        bus.data_ok_i = 1'b1; bus.rdata_i = 32'hDEAD_BEEF;
        #1;
        check("ldw_resp_valid", {63'd0, bus.mem_to_wb_valid_o}, 64'd1);
        check("ldw_resp_allowin", {63'd0, bus.mem_allowin_o}, 64'd0);
        tick();
        bus.data_ok_i = 1'b0; bus.rdata_i = 32'h0;
        for (int i = 0; i < 2; i++) begin
            check("ldw_hold_state", st(), 64'd2);
            #1;
            check("ldw_hold_wdata", {32'd0, fwd_wdata_o}, 64'hDEAD_BEEF);
            check("ldw_hold_pending", {63'd0, fwd_load_pending_o}, 64'd0);
            if (i == 1) bus.wb_allowin_i = 1'b1;
            tick();
        end
        check("ldw_release_state", st(), 64'd0);

        // Redo the release cycle observing outputs as wb_allowin_i rises
        bus.wb_allowin_i = 1'b0; bus.data_ok_i = 1'b1; bus.rdata_i = 32'hDEAD_BEEF;
        tick();
        bus.data_ok_i = 1'b0; bus.rdata_i = 32'h0; bus.wb_allowin_i = 1'b1;
        #1;
        check("ldw_rel_wdata", {32'd0, mem_to_wb_obus[31:0]}, 64'hDEAD_BEEF);
        check("ldw_rel_allowin", {63'd0, bus.mem_allowin_o}, 64'd1);
        tick();
        check("ldw_rel_state", st(), 64'd0);

        // Flush in WAIT: the stale response is dropped, the next load gets its own
        tick();
        check("fl_wait_state", st(), 64'd1);
        bus.excep_flush_i = 1'b1;
        #1;
        check("fl_to_wb_valid", {63'd0, bus.mem_to_wb_valid_o}, 64'd0);
        tick();
        check("fl_state", st(), 64'd0);
        check("fl_cnt", cnt(), 64'd1);
        bus.excep_flush_i = 1'b0; bus.data_ok_i = 1'b1; bus.rdata_i = 32'hAAAA_5555;
        #1;
        check("fl_drop_valid", {63'd0, bus.mem_to_wb_valid_o}, 64'd0);
        check("fl_drop_pending", {63'd0, fwd_load_pending_o}, 64'd1);
        tick();
        check("fl_drop_cnt", cnt(), 64'd0);
        check("fl_drop_state", st(), 64'd1);
        bus.rdata_i = 32'h1111_2222;
        #1;
        check("fl_new_valid", {63'd0, bus.mem_to_wb_valid_o}, 64'd1);
        check("fl_new_wdata", {32'd0, fwd_wdata_o}, 64'h1111_2222);
        tick();

        // Reset asserted mid-WAIT with a pending cancel
        bus.data_ok_i = 1'b0; bus.rdata_i = 32'h0;
        tick();
        bus.excep_flush_i = 1'b1;
        tick();
        bus.excep_flush_i = 1'b0;
        tick();
        check("rw_state_pre", st(), 64'd1);
        check("rw_cnt_pre", cnt(), 64'd1);
        rst_n = 1'b0;
        tick();
        check("rw_state", st(), 64'd0);
        check("rw_cnt", cnt(), 64'd0);
        check("rw_to_wb_valid", {63'd0, bus.mem_to_wb_valid_o}, 64'd0);
        check("rw_obus", {25'd0, mem_to_wb_obus}, 64'd0);
        check("rw_pending", {63'd0, fwd_load_pending_o}, 64'd0);
        check("rw_pc_inst", pc_inst_obus, 64'd0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Combinational-plus-control MEM stage of the single-issue LoongArch pipeline.
- Sits between the EX→MEM pipeline register and the MEM→WB pipeline register.
- Waits for the data-SRAM response of the instruction it holds, and buffers that response while WB stalls.
- Aligns and extends load data, then assembles the MEM→WB bus and the forwarding info for ID.
- Discards data responses that belong to instructions killed by an exception flush.

Parameters:
- CANCEL_W, 2, width of the discarded-response counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- mem_valid_i  in  1  EX→MEM register holds a valid instruction
- mem_allowin_o  out  1  MEM can accept a new instruction next cycle
- mem_to_wb_valid_o  out  1  MEM result may be latched by MEM→WB
- wb_allowin_i  in  1  WB can accept
- excep_flush_i  in  1  exception flush; kills the instruction in MEM
- pc_i, inst_i  in  32 each  PC and instruction
- mem_req_i  in  1  this instruction issued a data-SRAM request in EX
- load_type_i  in  3  0=none, 1=LD.B, 2=LD.H, 3=LD.W, 4=LD.BU, 5=LD.HU
- addr_low_i  in  2  address bits [1:0]
- alu_result_i  in  32  EX result / address
- rf_we_i  in  1  register write enable
- rf_waddr_i  in  5  destination register
- excep_i  in  1  exception already flagged upstream
- data_ok_i  in  1  data-SRAM response strobe (responses return in order)
- rdata_i  in  32  data-SRAM read data
- pc_inst_obus  out  64  {pc_i, inst_i}
- mem_to_wb_obus  out  39  {excep, rf_we, rf_waddr[4:0], rf_wdata[31:0]}
- fwd_we_o  out  1  forwarding write enable
- fwd_waddr_o  out  5  forwarding destination register
- fwd_wdata_o  out  32  forwarding write data
- fwd_load_pending_o  out  1  load data not yet available; ID must stall on a match

Behaviour:
- Reset (synchronous, rst_n=0):
  - state=IDLE, buf_valid=0, buf_data=0, cancel_cnt=0.
  - All outputs low/zero, because mem_valid_i is treated as low while rst_n=0.
- States:
  - IDLE: nothing outstanding.
  - WAIT: mem_valid_i & mem_req_i, response not yet received.
  - HOLD: response buffered, WB stalled.
- resp_hit = data_ok_i & (cancel_cnt==0).
- When data_ok_i & cancel_cnt!=0: cancel_cnt decrements and the response is dropped. This has priority; responses return in order.
- got = buf_valid | resp_hit.
- ready_go = !mem_req_i | excep_i | got.
- mem_to_wb_valid_o = mem_valid_i & ready_go & !excep_flush_i.
- mem_allowin_o = !mem_valid_i | (ready_go & wb_allowin_i).
- Transitions:
  - IDLE→WAIT when mem_valid_i & mem_req_i & !resp_hit.
  - IDLE/WAIT→HOLD when resp_hit & !wb_allowin_i. Latch buf_data=rdata_i, buf_valid=1.
  - Any state→IDLE when the instruction leaves (mem_to_wb_valid_o & wb_allowin_i). Clear buf_valid.
- Flush (excep_flush_i=1):
  - Forces IDLE and clears buf_valid.
  - If state==WAIT and !data_ok_i, cancel_cnt increments, saturating at 2^CANCEL_W-1.
  - A data_ok_i arriving in the flush cycle itself is consumed (no increment).
- Load data: raw = buf_valid ? buf_data : rdata_i.
  - Byte select raw[8*addr_low+7 -: 8]; halfword select raw[16*addr_low[1]+15 -: 16].
  - LD.B/LD.H sign-extend; LD.BU/LD.HU zero-extend; LD.W passes raw.
  - Misaligned addresses are handled upstream (excep_i).
- rf_wdata = load_type_i!=0 ? aligned : alu_result_i.
- rf_we output = rf_we_i & mem_valid_i & !excep_i.
- A store (mem_req_i, load_type_i=0) still waits for data_ok_i.
- Forwarding:
  - fwd_* mirror the bus when mem_valid_i.
  - fwd_load_pending_o = mem_valid_i & load_type_i!=0 & !got.
- Latency: 0 cycles added when the response arrives in the MEM cycle; otherwise stalls until data_ok_i.
- pc_inst_obus is passed through combinationally.

Test Plan:
- ADD, mem_req_i=0, alu_result_i=0x1234, rf_waddr_i=5, wb_allowin_i=1 → same cycle: mem_to_wb_valid_o=1, rf_wdata=0x00001234, mem_allowin_o=1.
- LD.B with addr_low_i=2, data_ok_i=1, rdata_i=0x12F45678 → rf_wdata=0xFFFFFFF4; the same access as LD.BU → 0x000000F4.
- LD.H with addr_low_i=2, data_ok_i delayed 3 cycles → mem_to_wb_valid_o=0 and fwd_load_pending_o=1 for 3 cycles; then rdata_i=0x8001ABCD gives rf_wdata=0xFFFF8001.
- LD.W response 0xDEADBEEF arrives while wb_allowin_i=0 for 2 cycles → state=HOLD; when wb_allowin_i rises, output is 0xDEADBEEF while data_ok_i=0.
- Flush in WAIT → cancel_cnt=1; the next data_ok_i (rdata=0xAAAA5555) is dropped; a following LD.W gets its own response 0x11112222 correctly.
- rst_n=0 asserted mid-WAIT with cancel_cnt=1 → next cycle state=IDLE, cancel_cnt=0, all outputs zero.
